// File: rtl/serial_add_carry_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the control FSM encoding and the default operand width.
package serial_add_carry_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_carry_full_add_bit.sv
// One-bit full adder used as the serial datapath core.
// Purely combinational; evaluated once per processed bit.
module full_add_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/serial_add_carry.sv
// Bit-serial adder: LSB-first, one bit per clock, WIDTH+1 cycle cadence.
// Result registers only update on the final bit so they stay stable while busy.
module serial_add_carry
  import serial_add_carry_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_s;
  logic fa_c;

  full_add_bit u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          s_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        s_d = {fa_s, s_q[WIDTH-1:1]};
        c_d = fa_c;
        if (cnt_q == LAST) begin
          // c_q is the carry into the MSB here
          sum_d   = {fa_s, s_q[WIDTH-1:1]};
          cout_d  = fa_c;
          ovf_d   = c_q ^ fa_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
